leaf_width_adapter: RTL

- Multi-channel stream width adapter between leaf_interface user ports and a wide-datapath HLS kernel inside a leaf wrapper.
- Input direction: packs RATIO consecutive PAYLOAD_BITS words per input port into one kernel word.
- Output direction: unpacks each kernel word into RATIO payload words per output port.
- Zero-bubble handshakes, sync flush; generalises the fixed 1-in/1-out, 32-bit direct connection.

---
 rtl/leaf_adapter_pkg.sv | 17 +
 rtl/leaf_pack_ch.sv | 86 ++++++++
 rtl/leaf_unpack_ch.sv | 74 +++++++
 rtl/leaf_width_adapter.sv | 71 +++++++
 4 files changed

// File: rtl/leaf_adapter_pkg.sv
// Shared constants and width helpers for the leaf_width_adapter channel modules.
package leaf_adapter_pkg;

    localparam int unsigned PAYLOAD_BITS_DEF = 32;
    localparam int unsigned CNT_BITS         = 16;

    // Slice index width; at least one bit so RATIO==1 still has a legal index.
    function automatic int unsigned idx_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Pack counter width: must hold 0..ratio inclusive.
    function automatic int unsigned cnt_width(input int unsigned ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/leaf_pack_ch.sv
// One input channel: packs RATIO payload words (slot 0 in the LSBs) into one kernel word.
// With LEAF_WIDTH_ADAPTER_CNT_EN it also counts delivered kernel words.
module leaf_pack_ch
    import leaf_adapter_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
    parameter int unsigned RATIO        = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [PAYLOAD_BITS-1:0]       din,
    input  logic                          vld,
    output logic                          ack,
    output logic [PAYLOAD_BITS*RATIO-1:0] tdata,
    output logic                          tvalid,
    input  logic                          tready
`ifdef LEAF_WIDTH_ADAPTER_CNT_EN
    ,
    output logic [CNT_BITS-1:0]           word_cnt
`endif
);

    localparam int unsigned CW = cnt_width(RATIO);
    localparam int unsigned KW = PAYLOAD_BITS * RATIO;
    localparam logic [CW-1:0] FULL_CNT = CW'(RATIO);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] wr_slot;
    logic [KW-1:0] data_d;
    logic          valid_d;
    logic          take;
    logic          deliver;

    // Accept while there is room, or when the kernel frees the slot this cycle.
    assign ack = !reset && ((cnt_q < FULL_CNT) || tready);

    always_comb begin
        take    = vld && ack;
        deliver = tvalid && tready;
        cnt_d   = cnt_q;
        data_d  = tdata;
        wr_slot = deliver ? '0 : cnt_q;
        if (flush) begin
            // Partial words are dropped; a completed word only leaves via the kernel.
            if (deliver || (cnt_q < FULL_CNT)) begin
                cnt_d = '0;
            end
        end else if (take) begin
            cnt_d = wr_slot + CW'(1);
            for (int unsigned k = 0; k < RATIO; k++) begin
                if (wr_slot == CW'(k)) begin
                    data_d[k*PAYLOAD_BITS +: PAYLOAD_BITS] = din;
                end
            end
        end else if (deliver) begin
            cnt_d = '0;
        end
        valid_d = (cnt_d == FULL_CNT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tdata  <= '0;
            tvalid <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tdata  <= data_d;
            tvalid <= valid_d;
        end
    end

`ifdef LEAF_WIDTH_ADAPTER_CNT_EN
    // Free-running delivered-word count; wraps naturally and ignores flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt <= '0;
        end else if (deliver) begin
            word_cnt <= word_cnt + CNT_BITS'(1);
        end
    end
`endif

endmodule

// File: rtl/leaf_unpack_ch.sv
// One output channel: splits a kernel word into RATIO payload words, LSB slice first.
module leaf_unpack_ch
    import leaf_adapter_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
    parameter int unsigned RATIO        = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PAYLOAD_BITS*RATIO-1:0] tdata,
    input  logic                          tvalid,
    output logic                          tready,
    output logic [PAYLOAD_BITS-1:0]       dout,
    output logic                          vld,
    input  logic                          ack
);

    localparam int unsigned IW = idx_width(RATIO);
    localparam int unsigned KW = PAYLOAD_BITS * RATIO;
    localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

    logic [KW-1:0]           hold_q;
    logic [KW-1:0]           hold_d;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           idx_d;
    logic                    full_d;
    logic [PAYLOAD_BITS-1:0] dout_d;
    logic                    pop;
    logic                    load;

    // Reload in the same cycle the last slice leaves so the stream has no bubble.
    assign tready = !reset && (!vld || ((idx_q == LAST_IDX) && ack));

    always_comb begin
        pop    = vld && ack;
        load   = tvalid && tready;
        hold_d = hold_q;
        idx_d  = idx_q;
        full_d = vld;
        dout_d = dout;
        if (load) begin
            hold_d = tdata;
            idx_d  = '0;
            full_d = 1'b1;
        end else if (pop) begin
            if (idx_q == LAST_IDX) begin
                idx_d  = '0;
                full_d = 1'b0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (idx_d == IW'(k)) begin
                dout_d = hold_d[k*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            idx_q  <= '0;
            vld    <= 1'b0;
            dout   <= '0;
        end else begin
            hold_q <= hold_d;
            idx_q  <= idx_d;
            vld    <= full_d;
            dout   <= dout_d;
        end
    end

endmodule

// File: rtl/leaf_width_adapter.sv
// Multi-channel width adapter between leaf_interface ports and a wide HLS kernel.
// Optional LEAF_WIDTH_ADAPTER_CNT_EN adds per-input-channel word_cnt (16 bits each).
module leaf_width_adapter
    import leaf_adapter_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS  = PAYLOAD_BITS_DEF,
    parameter int unsigned RATIO         = 2,
    parameter int unsigned NUM_IN_PORTS  = 1,
    parameter int unsigned NUM_OUT_PORTS = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    flush,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]                 vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]                 ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS*RATIO-1:0]  user_in_tdata,
    output logic [NUM_IN_PORTS-1:0]                 user_in_tvalid,
    input  logic [NUM_IN_PORTS-1:0]                 user_in_tready,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS*RATIO-1:0] user_out_tdata,
    input  logic [NUM_OUT_PORTS-1:0]                user_out_tvalid,
    output logic [NUM_OUT_PORTS-1:0]                user_out_tready,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                ack_interface2user
`ifdef LEAF_WIDTH_ADAPTER_CNT_EN
    ,
    output logic [NUM_IN_PORTS*CNT_BITS-1:0]        word_cnt
`endif
);

    localparam int unsigned KW = PAYLOAD_BITS * RATIO;

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_pack
        leaf_pack_ch #(
            .PAYLOAD_BITS (PAYLOAD_BITS),
            .RATIO        (RATIO)
        ) u_pack (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .din      (dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .vld      (vld_interface2user[i]),
            .ack      (ack_user2interface[i]),
            .tdata    (user_in_tdata[i*KW +: KW]),
            .tvalid   (user_in_tvalid[i]),
            .tready   (user_in_tready[i])
`ifdef LEAF_WIDTH_ADAPTER_CNT_EN
            ,
            .word_cnt (word_cnt[i*CNT_BITS +: CNT_BITS])
`endif
        );
    end

    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_unpack
        leaf_unpack_ch #(
            .PAYLOAD_BITS (PAYLOAD_BITS),
            .RATIO        (RATIO)
        ) u_unpack (
            .clk    (clk),
            .reset  (reset),
            .tdata  (user_out_tdata[j*KW +: KW]),
            .tvalid (user_out_tvalid[j]),
            .tready (user_out_tready[j]),
            .dout   (din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .vld    (vld_user2interface[j]),
            .ack    (ack_interface2user[j])
        );
    end

endmodule
